// File: rtl/pq_multer_pkg.sv
// Shared definitions for the PQ polynomial multiplier: opcodes and default sizes.
package pq_multer_pkg;

  parameter int PQ_OP_WIDTH = 7;

  parameter logic [PQ_OP_WIDTH-1:0] PQ_MULTER_WRITE = 7'h01;
  parameter logic [PQ_OP_WIDTH-1:0] PQ_MULTER_CALC  = 7'h02;
  parameter logic [PQ_OP_WIDTH-1:0] PQ_MULTER_READ  = 7'h03;

  parameter int PQ_MULTER_N_DEFAULT  = 16;
  parameter int PQ_MULTER_QW_DEFAULT = 16;

  // READ index that exposes the cycle counter when it is built in
  parameter logic [31:0] PQ_MULTER_CNT_IDX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pq_multer_mac.sv
// Single multiply-accumulate step: acc +/- a*b, everything modulo 2^QW.
module pq_multer_mac
  import pq_multer_pkg::*;
#(
  parameter int QW = PQ_MULTER_QW_DEFAULT
) (
  input  logic [QW-1:0] acc_i,
  input  logic [QW-1:0] a_i,
  input  logic [QW-1:0] b_i,
  input  logic          sub_i,
  output logic [QW-1:0] acc_o
);

  logic [QW-1:0] prodLow;

  // Only the low QW bits of the product matter under a 2^QW modulus
  assign prodLow = a_i * b_i;
  assign acc_o   = sub_i ? (acc_i - prodLow) : (acc_i + prodLow);

endmodule

// File: rtl/pq_multer_unit.sv
// Negacyclic polynomial multiplier responder, C = A*B mod (x^N+1) mod 2^QW.
// Optional macro PQ_MULTER_CYCLE_CNT_EN adds a CALC cycle counter readable at index 32'hFFFF_FFFF.
module pq_multer_unit
  import pq_multer_pkg::*;
#(
  parameter int N  = PQ_MULTER_N_DEFAULT,
  parameter int QW = PQ_MULTER_QW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic [PQ_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]            operand_a_i,
  input  logic [31:0]            operand_b_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [31:0]            result_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] i_q, j_q;
  logic          valid_q;
  logic [31:0]   result_q;
  logic [QW-1:0] aMem_q [N];
  logic [QW-1:0] bMem_q [N];
  logic [QW-1:0] cMem_q [N];

  logic          accept;
  logic          idxInRange;
  logic [IW-1:0] idx;
  logic [IW:0]   stepSum;
  logic [IW-1:0] stepK;
  logic          stepWrap;
  logic          lastStep;
  logic [QW-1:0] macOut;
  logic [31:0]   readData;

  assign ready_o    = (state_q == IDLE);
  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign accept     = enable_i && ready_o;
  assign idxInRange = (operand_b_i < 32'(N));
  assign idx        = operand_b_i[IW-1:0];

  // The carry out of i+j tells us the term wrapped past x^N and must be subtracted
  assign stepSum  = {1'b0, i_q} + {1'b0, j_q};
  assign stepK    = stepSum[IW-1:0];
  assign stepWrap = stepSum[IW];
  assign lastStep = (i_q == IDX_MAX) && (j_q == IDX_MAX);

  pq_multer_mac #(.QW(QW)) u_mac (
    .acc_i (cMem_q[stepK]),
    .a_i   (aMem_q[i_q]),
    .b_i   (bMem_q[j_q]),
    .sub_i (stepWrap),
    .acc_o (macOut)
  );

`ifdef PQ_MULTER_CYCLE_CNT_EN
  logic [31:0] cycleCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCnt_q <= '0;
    end else if (accept && operator_i == PQ_MULTER_CALC) begin
      cycleCnt_q <= '0;
    end else if (state_q != IDLE) begin
      cycleCnt_q <= cycleCnt_q + 32'd1;
    end
  end
`endif

  always_comb begin
    readData = '0;
    if (idxInRange) begin
      readData = 32'(cMem_q[idx]);
    end
`ifdef PQ_MULTER_CYCLE_CNT_EN
    else if (operand_b_i == PQ_MULTER_CNT_IDX) begin
      readData = cycleCnt_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && operator_i == PQ_MULTER_CALC) state_d = CALC;
      CALC:    if (lastStep) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      for (int n = 0; n < N; n++) begin
        aMem_q[n] <= '0;
        bMem_q[n] <= '0;
        cMem_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            valid_q  <= (operator_i != PQ_MULTER_CALC);
            result_q <= '0;
            if (operator_i == PQ_MULTER_WRITE && idxInRange) begin
              aMem_q[idx] <= operand_a_i[QW-1:0];
              bMem_q[idx] <= operand_a_i[16+QW-1:16];
            end else if (operator_i == PQ_MULTER_READ) begin
              result_q <= readData;
            end else if (operator_i == PQ_MULTER_CALC) begin
              i_q <= '0;
              j_q <= '0;
              for (int n = 0; n < N; n++) begin
                cMem_q[n] <= '0;
              end
            end
          end
        end
        CALC: begin
          cMem_q[stepK] <= macOut;
          j_q <= j_q + IW'(1);
          if (j_q == IDX_MAX) begin
            i_q <= i_q + IW'(1);
          end
          if (lastStep) begin
            valid_q  <= 1'b1;
            result_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_multer_unit.sv
// Directed self-checking bench for pq_multer_unit at N=16, QW=16.
module tb_pq_multer_unit;
  import pq_multer_pkg::*;

  localparam int N = 16;
  localparam int FULL_CALC_LOW = N * N + 1;

`ifdef PQ_MULTER_CYCLE_CNT_EN
  localparam logic [31:0] CNT_EXPECT = 32'd257;
`else
  localparam logic [31:0] CNT_EXPECT = 32'd0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   enable_i;
  logic [PQ_OP_WIDTH-1:0] operator_i;
  logic [31:0]            operand_a_i;
  logic [31:0]            operand_b_i;
  logic                   ready_o;
  logic                   valid_o;
  logic [31:0]            result_o;

  int checks   = 0;
  int failures = 0;
  int lastWait = 0;

  pq_multer_unit #(.N(N), .QW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable_i),
    .operator_i  (operator_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .result_o    (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Holds the request from a falling edge until ready_o lets it through; returns #1 after the accept edge
  task automatic applyStimulus(input logic [PQ_OP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b);
    int waitCnt = 0;
    @(negedge clk);
    enable_i    = 1'b1;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    while (!ready_o && waitCnt < 2000) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!ready_o) checkOutput("acceptTimeout", {31'd0, ready_o}, 32'd1);
    lastWait = waitCnt;
    @(posedge clk);
    #1;
    enable_i = 1'b0;
  endtask

  task automatic writeCoef(input int idx, input logic [15:0] a, input logic [15:0] b);
    applyStimulus(PQ_MULTER_WRITE, {b, a}, 32'(idx));
  endtask

  task automatic clearAB();
    for (int k = 0; k < N; k++) writeCoef(k, 16'h0, 16'h0);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] idx, input logic [31:0] expected);
    applyStimulus(PQ_MULTER_READ, 32'h0, idx);
    checkOutput({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
    checkOutput(tag, result_o, expected);
  endtask

  task automatic runCalc(input string tag);
    int lowCnt = 0;
    int validCnt = 0;
    applyStimulus(PQ_MULTER_CALC, 32'h0, 32'h0);
    while (!ready_o && lowCnt < 2000) begin
      @(posedge clk);
      #1;
      lowCnt++;
      if (valid_o) validCnt++;
    end
    checkOutput({tag, ".readyLow"}, 32'(lowCnt), 32'(FULL_CALC_LOW));
    checkOutput({tag, ".donePulses"}, 32'(validCnt), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    enable_i    = 1'b0;
    operator_i  = '0;
    operand_a_i = '0;
    operand_b_i = '0;
    #1;
    checkOutput("reset.ready", {31'd0, ready_o}, 32'd1);
    checkOutput("reset.valid", {31'd0, valid_o}, 32'd0);
    checkOutput("reset.result", result_o, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // WRITE acknowledges with a zero result; an unknown opcode is acknowledged the same way
    writeCoef(0, 16'h0001, 16'h0003);
    checkOutput("write.valid", {31'd0, valid_o}, 32'd1);
    checkOutput("write.result", result_o, 32'd0);
    applyStimulus(7'h55, 32'h1234_5678, 32'd2);
    checkOutput("otherOp.valid", {31'd0, valid_o}, 32'd1);
    checkOutput("otherOp.result", result_o, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("otherOp.pulseEnd", {31'd0, valid_o}, 32'd0);

    // Identity: A = 1, so C must equal B
    for (int k = 1; k < N; k++) writeCoef(k, 16'h0, 16'(k + 3));
    runCalc("identity");
    for (int k = 0; k < N; k++) readCheck($sformatf("identity.C[%0d]", k), 32'(k), 32'(k + 3));

    // An out-of-range WRITE must not alias onto a low index
    writeCoef(16, 16'h0005, 16'h0007);
    runCalc("afterOorWrite");
    readCheck("oorWrite.C[0]", 32'd0, 32'd3);
    readCheck("oorWrite.C[5]", 32'd5, 32'd8);
    readCheck("oorRead.idx16", 32'd16, 32'd0);
    readCheck("cycleCount", 32'hFFFF_FFFF, CNT_EXPECT);

    // x * x^15 = x^16 = -1
    clearAB();
    writeCoef(1, 16'h0001, 16'h0000);
    writeCoef(15, 16'h0000, 16'h0001);
    runCalc("negacyclic");
    for (int k = 0; k < N; k++)
      readCheck($sformatf("negacyclic.C[%0d]", k), 32'(k), (k == 0) ? 32'h0000_FFFF : 32'h0);

    clearAB();
    writeCoef(0, 16'hFFFF, 16'h0002);
    runCalc("truncation");
    readCheck("truncation.C[0]", 32'd0, 32'h0000_FFFE);
    readCheck("truncation.C[1]", 32'd1, 32'h0);

    // READ raised two cycles into CALC must wait until the unit is back in IDLE
    applyStimulus(PQ_MULTER_CALC, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    applyStimulus(PQ_MULTER_READ, 32'h0, 32'd0);
    checkOutput("busyHold.waitCycles", 32'(lastWait), 32'd255);
    checkOutput("busyHold.valid", {31'd0, valid_o}, 32'd1);
    checkOutput("busyHold.result", result_o, 32'h0000_FFFE);
    @(posedge clk);
    #1;
    checkOutput("busyHold.pulseEnd", {31'd0, valid_o}, 32'd0);

    // Reset partway through CALC
    applyStimulus(PQ_MULTER_CALC, 32'h0, 32'h0);
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midReset.ready", {31'd0, ready_o}, 32'd1);
    checkOutput("midReset.valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    readCheck("midReset.C[0]", 32'd0, 32'd0);
    readCheck("midReset.count", 32'hFFFF_FFFF, 32'd0);
    runCalc("postReset");
    readCheck("postReset.C[0]", 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
